// File: rtl/print_arbiter_pkg.sv
// Shared definitions for the print arbiter: FSM encoding, datapath widths
// and the pointer wrap helper used after each completed grant.
package print_arbiter_pkg;

   localparam int WORD_W = 32;
   localparam int CNT_W  = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   function automatic int wrap_inc(input int value, input int modulus);
      return (value + 1 >= modulus) ? 0 : value + 1;
   endfunction

endpackage

// File: rtl/print_arbiter_rr_picker.sv
// Round-robin winner selection: first set request at or above ptr,
// wrapping from N-1 back to 0.
module rr_picker #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic                 any,
   output logic [$clog2(N)-1:0] idx
);

   localparam int IW = $clog2(N);

   int pos;

   always_comb begin
      any = 1'b0;
      idx = '0;
      pos = 0;
      for (int k = 0; k < N; k++) begin
         pos = int'(ptr) + k;
         if (pos >= N) pos = pos - N;
         if (!any && req[pos]) begin
            any = 1'b1;
            idx = IW'(pos);
         end
      end
   end

endmodule

// File: rtl/print_arbiter.sv
// Shares one PRINT engine between N requesters; one transaction at a time,
// round-robin fairness, and a cycle timeout on the PRINT acknowledge.
module print_arbiter
   import print_arbiter_pkg::*;
#(
   parameter int N   = 4,
   parameter int TMO = 65535
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N-1:0]           req,
   input  logic [WORD_W*N-1:0]    dout,
   input  logic [N-1:0]           typ,
   output logic [N-1:0]           ack,
   output logic                   err,
   output logic                   busy,
   output logic [$clog2(N)-1:0]   gnt_id,
   output logic                   req_tx,
   output logic [WORD_W-1:0]      dout_tx,
   output logic                   type_tx,
   input  logic                   ack_tx
);

   localparam int IW = $clog2(N);
   localparam logic [N-1:0]     ACK_ONE   = N'(1);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TMO - 1);

   state_t          state;
   logic [IW-1:0]   ptr;
   logic [CNT_W-1:0] cnt;
   logic            err_flag;
   logic            pick_any;
   logic [IW-1:0]   pick_idx;

   rr_picker #(.N(N)) u_picker (
      .req (req),
      .ptr (ptr),
      .any (pick_any),
      .idx (pick_idx)
   );

   assign busy = (state != IDLE);
   assign err  = (state == DONE) && err_flag;

   // Requester inputs are only looked at in IDLE, so the word and type
   // latched at grant stay put until the transaction retires.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         ptr      <= '0;
         gnt_id   <= '0;
         cnt      <= '0;
         err_flag <= 1'b0;
         req_tx   <= 1'b0;
         ack      <= '0;
         dout_tx  <= '0;
         type_tx  <= 1'b0;
      end else begin
         req_tx <= 1'b0;
         ack    <= '0;
         case (state)
            IDLE: begin
               if (pick_any) begin
                  gnt_id  <= pick_idx;
                  dout_tx <= dout[WORD_W*pick_idx +: WORD_W];
                  type_tx <= typ[pick_idx];
                  req_tx  <= 1'b1;
                  state   <= ISSUE;
               end
            end
            ISSUE: begin
               cnt      <= '0;
               err_flag <= 1'b0;
               state    <= WAIT;
            end
            WAIT: begin
               // A real acknowledge wins even on the final timeout cycle.
               if (ack_tx) begin
                  err_flag <= 1'b0;
                  ack      <= ACK_ONE << gnt_id;
                  state    <= DONE;
               end else if (cnt == CNT_LAST) begin
                  err_flag <= 1'b1;
                  ack      <= ACK_ONE << gnt_id;
                  state    <= DONE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            DONE: begin
               ptr   <= IW'(wrap_inc(int'(gnt_id), N));
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
